// File: rtl/decoder_2to4.sv
// -----------------------------------------------------------------------------
// decoder_2to4
//
// Registered 2-to-4 line decoder with an active-high enable. One clock of
// latency. Downstream logic sees a clean one-hot select code (or one-cold
// when OUT_ACTIVE_LOW=1) with no decode glitches.
//
// Parameters
//   OUT_ACTIVE_LOW  0: an asserted output bit is 1 and the idle value is 0000
//                   1: every Y bit is inverted and the idle value is 1111
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active high, overrides E and A
//   A          in   2  select code, A[1] is the MSB
//   E          in   1  enable, active high
//   Y          out  4  registered decoded output; Y[i] asserted when E=1, A=i
//   valid      out  1  registered copy of E
//   y_changed  out  1  one-cycle pulse when the registered Y value changes
// -----------------------------------------------------------------------------
module decoder_2to4 #(
   parameter logic OUT_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] A,
   input  logic       E,
   output logic [3:0] Y,
   output logic       valid,
   output logic       y_changed
);

   // Value Y takes when nothing is selected (disabled or in reset).
   localparam logic [3:0] IDLE = OUT_ACTIVE_LOW ? 4'b1111 : 4'b0000;

   logic [3:0] dec_hi;        // active-high one-hot decode of A, gated by E
   logic [3:0] y_d;
   logic [3:0] y_q;
   logic       valid_d;
   logic       valid_q;
   logic       y_changed_d;
   logic       y_changed_q;

   // E is ANDed in per bit so an unknown A while disabled cannot leak into Y.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dec
         assign dec_hi[gi] = E & (A == 2'(gi));
      end
   endgenerate

   always_comb begin
      y_d         = OUT_ACTIVE_LOW ? ~dec_hi : dec_hi;
      valid_d     = E;
      // Compared against the register contents, not the previous inputs.
      y_changed_d = (y_d != y_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q         <= IDLE;
         valid_q     <= 1'b0;
         y_changed_q <= 1'b0;
      end else begin
         y_q         <= y_d;
         valid_q     <= valid_d;
         y_changed_q <= y_changed_d;
      end
   end

   assign Y         = y_q;
   assign valid     = valid_q;
   assign y_changed = y_changed_q;

endmodule

// File: tb/tb_decoder_2to4.sv
// -----------------------------------------------------------------------------
// tb_decoder_2to4
//
// Directed test of decoder_2to4. Two instances share the same stimulus: one
// with active-high outputs and one with OUT_ACTIVE_LOW=1. Expected values are
// written by hand for the active-high form; the active-low instance must show
// the bitwise inverse of Y with identical valid and y_changed.
// -----------------------------------------------------------------------------
module tb_decoder_2to4;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] A;
   logic       E;

   logic [3:0] y_hi,  y_lo;
   logic       v_hi,  v_lo;
   logic       c_hi,  c_lo;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #10 clk = ~clk;   // 20 ns period

   decoder_2to4 #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .E         (E),
      .Y         (y_hi),
      .valid     (v_hi),
      .y_changed (c_hi)
   );

   decoder_2to4 #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .E         (E),
      .Y         (y_lo),
      .valid     (v_lo),
      .y_changed (c_lo)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Legal Y patterns only: one-hot when valid, zero when not (checked on the
   // active-high view, so the active-low output is inverted first).
   function automatic logic legal(input logic [3:0] y_act, input logic v);
      if (v) return $onehot(y_act);
      return (y_act == 4'b0000);
   endfunction

   // Advance one clock, sample 1 ns after the edge, compare both instances.
   task automatic step(input string name, input logic [3:0] ey,
                       input logic ev, input logic ec);
      @(posedge clk);
      #1;
      $display("step %-14s rst=%b E=%b A=%b | hi Y=%b v=%b c=%b | lo Y=%b v=%b c=%b",
               name, rst, E, A, y_hi, v_hi, c_hi, y_lo, v_lo, c_lo);
      chk({name, ".hi.Y"}, y_hi, ey);
      chk({name, ".hi.valid"}, {3'b000, v_hi}, {3'b000, ev});
      chk({name, ".hi.ychg"}, {3'b000, c_hi}, {3'b000, ec});
      chk({name, ".lo.Y"}, y_lo, ~ey);
      chk({name, ".lo.valid"}, {3'b000, v_lo}, {3'b000, ev});
      chk({name, ".lo.ychg"}, {3'b000, c_lo}, {3'b000, ec});
      chk({name, ".hi.legal"}, {3'b000, legal(y_hi, v_hi)}, 4'b0001);
      chk({name, ".lo.legal"}, {3'b000, legal(~y_lo, v_lo)}, 4'b0001);
   endtask

   initial begin
      // Reset held two cycles with an active select pending.
      rst = 1'b1; E = 1'b1; A = 2'b11;
      @(posedge clk); #1;
      step("rst1",      4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      step("rst_rel",   4'b1000, 1'b1, 1'b1);

      // Disabled: sweep A, output stays idle.
      E = 1'b0; A = 2'b00;
      step("dis_a0",    4'b0000, 1'b0, 1'b1);
      A = 2'b01;
      step("dis_a1",    4'b0000, 1'b0, 1'b0);
      A = 2'b10;
      step("dis_a2",    4'b0000, 1'b0, 1'b0);
      A = 2'b11;
      step("dis_a3",    4'b0000, 1'b0, 1'b0);

      // Enable sequence.
      E = 1'b0; A = 2'b00;
      step("en_off",    4'b0000, 1'b0, 1'b0);
      E = 1'b1;
      step("en_a0",     4'b0001, 1'b1, 1'b1);
      A = 2'b01;
      step("en_a1",     4'b0010, 1'b1, 1'b1);
      A = 2'b10;
      step("en_a2",     4'b0100, 1'b1, 1'b1);
      A = 2'b11;
      step("en_a3",     4'b1000, 1'b1, 1'b1);

      // Hold three cycles, then change E and A together.
      E = 1'b1; A = 2'b10;
      step("hold1",     4'b0100, 1'b1, 1'b1);
      step("hold2",     4'b0100, 1'b1, 1'b0);
      step("hold3",     4'b0100, 1'b1, 1'b0);
      E = 1'b0; A = 2'b01;
      step("simul",     4'b0000, 1'b0, 1'b1);
      step("simul_hold",4'b0000, 1'b0, 1'b0);

      // Reset in the middle of operation.
      E = 1'b1; A = 2'b01;
      step("run_a1",    4'b0010, 1'b1, 1'b1);
      rst = 1'b1;
      step("mid_rst",   4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      step("mid_rel",   4'b0010, 1'b1, 1'b1);

      // Unknown select while disabled must not reach Y.
      E = 1'b0; A = 2'bxx;
      step("ax_dis1",   4'b0000, 1'b0, 1'b1);
      step("ax_dis2",   4'b0000, 1'b0, 0);

      // Polarity sequence (low instance expects 1110, 0111, 1111).
      E = 1'b1; A = 2'b00;
      step("pol_a0",    4'b0001, 1'b1, 1'b1);
      A = 2'b11;
      step("pol_a3",    4'b1000, 1'b1, 1'b1);
      E = 1'b0;
      step("pol_off",   4'b0000, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
